// File: rtl/key_dir_decoder.sv
// Keypad-to-snake command decoder: synchronizes and debounces the press flag,
// emits one event per press, and buffers reversal-safe direction requests until the step tick.
module key_dir_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [3:0]  KEY_UP          = 4'h2,
    parameter logic [3:0]  KEY_DOWN        = 4'h8,
    parameter logic [3:0]  KEY_LEFT        = 4'h4,
    parameter logic [3:0]  KEY_RIGHT       = 4'h6,
    parameter logic [3:0]  KEY_PAUSE       = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_pressed_flag,
    input  logic [3:0] keyboard_val,
    input  logic       step_tick,
    output logic [1:0] dir,
    output logic       pause,
    output logic       pending,
    output logic       key_event,
    output logic [3:0] key_code
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StPressWait = 2'd1;
    localparam logic [1:0] StHeld      = 2'd2;
    localparam logic [1:0] StRelWait   = 2'd3;

    logic            flag1_q, flag2_q;
    logic [3:0]      val1_q, val2_q;
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            key_event_q, key_event_d;
    logic [3:0]      key_code_q, key_code_d;
    logic [1:0]      dir_q, dir_d;
    logic            pause_q, pause_d;
    logic            pending_q, pending_d;
    logic [1:0]      pend_dir_q, pend_dir_d;

    logic       sflag;
    logic       fire;
    logic       is_dir;
    logic [1:0] req;
    logic       commit;
    logic [1:0] ref_dir;
    logic       accept;

    assign sflag = flag2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        case (state_q)
            StIdle: begin
                if (!sflag) begin
                    state_d = StPressWait;
                    cnt_d   = '0;
                end
            end
            StPressWait: begin
                if (sflag) begin
                    state_d = StIdle;
                end else if (cnt_q == CntMax) begin
                    state_d = StHeld;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHeld: begin
                if (sflag) begin
                    state_d = StRelWait;
                    cnt_d   = '0;
                end
            end
            StRelWait: begin
                // Returning low here is a bounce of the same press: no new event.
                if (!sflag) begin
                    state_d = StHeld;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        is_dir = 1'b1;
        req    = 2'b00;
        if (val2_q == KEY_UP) begin
            req = 2'b00;
        end else if (val2_q == KEY_DOWN) begin
            req = 2'b01;
        end else if (val2_q == KEY_LEFT) begin
            req = 2'b10;
        end else if (val2_q == KEY_RIGHT) begin
            req = 2'b11;
        end else begin
            is_dir = 1'b0;
        end
    end

    always_comb begin
        commit  = step_tick && pending_q && !pause_q;
        // A request is judged against the direction in force after this edge.
        ref_dir = commit ? pend_dir_q : dir_q;
        // Opposites differ only in bit 0, so a legal turn must change bit 1.
        accept  = fire && is_dir && (req[1] != ref_dir[1]);

        dir_d       = commit ? pend_dir_q : dir_q;
        pend_dir_d  = accept ? req : pend_dir_q;
        pending_d   = accept ? 1'b1 : (commit ? 1'b0 : pending_q);
        pause_d     = (fire && (val2_q == KEY_PAUSE)) ? ~pause_q : pause_q;
        key_event_d = fire;
        key_code_d  = fire ? val2_q : key_code_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag1_q     <= 1'b1;
            flag2_q     <= 1'b1;
            val1_q      <= 4'h0;
            val2_q      <= 4'h0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            key_event_q <= 1'b0;
            key_code_q  <= 4'h0;
            dir_q       <= 2'b11;
            pause_q     <= 1'b0;
            pending_q   <= 1'b0;
            pend_dir_q  <= 2'b11;
        end else begin
            flag1_q     <= key_pressed_flag;
            flag2_q     <= flag1_q;
            val1_q      <= keyboard_val;
            val2_q      <= val1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_event_q <= key_event_d;
            key_code_q  <= key_code_d;
            dir_q       <= dir_d;
            pause_q     <= pause_d;
            pending_q   <= pending_d;
            pend_dir_q  <= pend_dir_d;
        end
    end

    assign dir       = dir_q;
    assign pause     = pause_q;
    assign pending   = pending_q;
    assign key_event = key_event_q;
    assign key_code  = key_code_q;

endmodule
